// File: rtl/alu_div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, word width
// and the sign-extension / negation helpers used on results.
package alu_div_pkg;

    // System datapath width; the divider's XLEN parameter defaults to this.
    localparam int SYS_XLEN = 64;

    // Operand width used by the W-suffixed instructions.
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

    // Two's-complement negation at system width.
    function automatic logic [SYS_XLEN-1:0] twos_neg(input logic [SYS_XLEN-1:0] x);
        return ~x + SYS_XLEN'(1);
    endfunction

    // Sign-extend a word result to system width.
    function automatic logic [SYS_XLEN-1:0] sext_word(input logic [WORD_W-1:0] x);
        return {{(SYS_XLEN-WORD_W){x[WORD_W-1]}}, x};
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, subtract
// the divisor when it fits and record the quotient bit.
module alu_div_step
    import alu_div_pkg::*;
#(
    parameter int XLEN = SYS_XLEN
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    // The shifted remainder needs one extra bit; the result always fits XLEN.
    logic [XLEN:0] rem_sh;
    logic          fits;

    // Trial subtraction and quotient bit selection.
    always_comb begin
        rem_sh = {rem_i, quo_i[XLEN-1]};
        fits   = (rem_sh >= {1'b0, div_i});
        rem_o  = fits ? (rem_sh[XLEN-1:0] - div_i) : rem_sh[XLEN-1:0];
        quo_o  = {quo_i[XLEN-2:0], fits};
    end

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle radix-2 restoring divider with RISC-V M semantics, word mode,
// flush and result backpressure.
// Optional macro ALU_DIV_EARLY_OUT_EN: divisor zero or divisor magnitude
// larger than dividend magnitude skip the iteration loop (latency 2).
//
// Handshake: a request transfers on a rising edge where in_valid and
// in_ready are both high (in_ready is high only in IDLE). A result is
// presented with out_valid high and stays stable until a rising edge with
// out_ready high. flush (and rst) override both handshakes on that edge.
module alu_div_seq
    import alu_div_pkg::*;
#(
    parameter int XLEN = SYS_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_sr1_signed,
    input  logic            is_sr2_signed,
    input  logic            is_word,
    input  logic [XLEN-1:0] sr1_data,
    input  logic [XLEN-1:0] sr2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] div_result,
    output logic [XLEN-1:0] rem_result
);

    localparam int CNT_W = $clog2(XLEN + 1);

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] div_res_q, div_res_d;
    logic [XLEN-1:0] rem_res_q, rem_res_d;

    logic            sign_a_in, sign_b_in;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] q_fix, r_fix;
    logic            skip_loop;

    alu_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Incoming operand signs and magnitudes within the active width.
    always_comb begin
        sign_a_in = is_sr1_signed & (is_word ? sr1_data[WORD_W-1] : sr1_data[XLEN-1]);
        sign_b_in = is_sr2_signed & (is_word ? sr2_data[WORD_W-1] : sr2_data[XLEN-1]);
        a_ext = is_word ? {{(XLEN-WORD_W){sign_a_in}}, sr1_data[WORD_W-1:0]} : sr1_data;
        b_ext = is_word ? {{(XLEN-WORD_W){sign_b_in}}, sr2_data[WORD_W-1:0]} : sr2_data;
        a_mag = sign_a_in ? twos_neg(a_ext) : a_ext;
        b_mag = sign_b_in ? twos_neg(b_ext) : b_ext;
`ifdef ALU_DIV_EARLY_OUT_EN
        skip_loop = (b_mag == '0) || (b_mag > a_mag);
`else
        skip_loop = 1'b0;
`endif
    end

    // Sign correction, divide-by-zero quotient and word sign-extension.
    // Signed overflow needs nothing special: |MIN|/1 negated is MIN again.
    always_comb begin
        q_fix = quo_q;
        r_fix = rem_q;
        if ((sign_a_q ^ sign_b_q) && (dvs_q != '0)) begin
            q_fix = twos_neg(quo_q);
        end
        if (sign_a_q) begin
            r_fix = twos_neg(rem_q);
        end
        if (dvs_q == '0) begin
            q_fix = '1;
        end
        if (word_q) begin
            q_fix = sext_word(q_fix[WORD_W-1:0]);
            r_fix = sext_word(r_fix[WORD_W-1:0]);
        end
    end

    // Next-state and datapath updates; flush returns to IDLE from anywhere.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        word_d    = word_q;
        div_res_d = div_res_q;
        rem_res_d = rem_res_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_a_d = sign_a_in;
                    sign_b_d = sign_b_in;
                    word_d   = is_word;
                    dvs_d    = b_mag;
                    rem_d    = '0;
                    // Word dividends start at the top so the loop consumes them first.
                    quo_d    = is_word ? (a_mag << (XLEN - WORD_W)) : a_mag;
                    cnt_d    = is_word ? CNT_W'(WORD_W) : CNT_W'(XLEN);
                    state_d  = ST_CALC;
                    if (skip_loop) begin
                        rem_d   = a_mag;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_FIXUP;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                div_res_d = q_fix;
                rem_res_d = r_fix;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // State and datapath registers; reset also clears the held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            word_q    <= 1'b0;
            div_res_q <= '0;
            rem_res_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            word_q    <= word_d;
            div_res_q <= div_res_d;
            rem_res_q <= rem_res_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign div_result = div_res_q;
    assign rem_result = rem_res_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Bench for alu_div_seq: directed RISC-V corner cases, handshake/flush/reset
// scenarios and randomized operations against an integer-arithmetic model.
module tb_alu_div_seq;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            is_sr1_signed;
    logic            is_sr2_signed;
    logic            is_word;
    logic [XLEN-1:0] sr1_data;
    logic [XLEN-1:0] sr2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] div_result;
    logic [XLEN-1:0] rem_result;

    int total;
    int bad;

    // Expected {quotient, remainder} for the operation in flight.
    logic [2*XLEN-1:0] exp_q[$];

    alu_div_seq #(
        .XLEN (XLEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .is_sr1_signed (is_sr1_signed),
        .is_sr2_signed (is_sr2_signed),
        .is_word       (is_word),
        .sr1_data      (sr1_data),
        .sr2_data      (sr2_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .div_result    (div_result),
        .rem_result    (rem_result)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison point
    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Operand value as a mathematical integer under the active width/sign.
    function automatic logic signed [129:0] op_val(input logic [XLEN-1:0] x, input logic s, input logic w);
        logic signed [129:0] v;
        if (w) begin
            v = $signed({98'b0, x[31:0]});
            if (s && x[31]) v = v - (130'sd1 <<< 32);
        end else begin
            v = $signed({66'b0, x});
            if (s && x[63]) v = v - (130'sd1 <<< 64);
        end
        return v;
    endfunction

    // Reference result: truncating division, RISC-V divide-by-zero rule.
    function automatic logic [2*XLEN-1:0] ref_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                 input logic s1, input logic s2, input logic w);
        logic signed [129:0] va, vb, vq, vr;
        logic [XLEN-1:0] q, r;
        va = op_val(a, s1, w);
        vb = op_val(b, s2, w);
        if (vb == 0) begin
            vq = '1;
            vr = va;
        end else begin
            vq = va / vb;
            vr = va % vb;
        end
        q = vq[63:0];
        r = vr[63:0];
        if (w) begin
            q = {{32{q[31]}}, q[31:0]};
            r = {{32{r[31]}}, r[31:0]};
        end
        return {q, r};
    endfunction

    // Expected cycles from the accepting cycle to the first out_valid cycle.
    function automatic int ref_lat(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic s1, input logic s2, input logic w);
        logic signed [129:0] va, vb;
        va = op_val(a, s1, w);
        vb = op_val(b, s2, w);
        if (va < 0) va = -va;
        if (vb < 0) vb = -vb;
`ifdef ALU_DIV_EARLY_OUT_EN
        if (vb == 0 || vb > va) return 2;
`endif
        return w ? 34 : 66;
    endfunction

    // Present one request at a negedge; returns after the accepting edge.
    task automatic send(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic s1, input logic s2, input logic w);
        int n;
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_send", {63'b0, in_ready}, 64'd1);
        sr1_data = a;
        sr2_data = b;
        is_sr1_signed = s1;
        is_sr2_signed = s2;
        is_word = w;
        in_valid = 1'b1;
        @(negedge clk);
        // Scramble the inputs: only the latched copy may matter now.
        in_valid = 1'b0;
        sr1_data = {$urandom, $urandom};
        sr2_data = {$urandom, $urandom};
        is_sr1_signed = 1'($urandom_range(0, 1));
        is_sr2_signed = 1'($urandom_range(0, 1));
        is_word = 1'($urandom_range(0, 1));
    endtask

    // Full transaction with latency, stall and result checks.
    task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic s1, input logic s2, input logic w,
                          input int hold, input string tag);
        logic [2*XLEN-1:0] e;
        int cyc;
        exp_q.push_back(ref_div(a, b, s1, s2, w));
        out_ready = 1'b0;
        send(a, b, s1, s2, w);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(ref_lat(a, b, s1, s2, w)));
        for (int i = 0; i < hold; i++) begin
            check({tag, "_stall_in_ready"}, {63'b0, in_ready}, 64'd0);
            check({tag, "_stall_out_valid"}, {63'b0, out_valid}, 64'd1);
            check({tag, "_stall_div"}, div_result, exp_q[0][2*XLEN-1:XLEN]);
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check({tag, "_div"}, div_result, e[2*XLEN-1:XLEN]);
        check({tag, "_rem"}, rem_result, e[XLEN-1:0]);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, {63'b0, out_valid}, 64'd0);
    endtask

    // Directed and random sequence
    initial begin
        logic [XLEN-1:0] ra, rb;
        logic rs1, rs2, rw;
        int sel;
        int saw;

        total = 0;
        bad = 0;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        is_sr1_signed = 1'b0;
        is_sr2_signed = 1'b0;
        is_word = 1'b0;
        sr1_data = '0;
        sr2_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", {63'b0, in_ready}, 64'd1);
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_div", div_result, 64'd0);
        check("reset_rem", rem_result, 64'd0);

        run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 0, "divu_100_7");
        run_op(-64'sd7, 64'd2, 1'b1, 1'b1, 1'b0, 0, "div_m7_2");
        run_op(64'd7, -64'sd2, 1'b1, 1'b1, 1'b0, 0, "div_7_m2");
        run_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b1, 1'b0, 0, "div_overflow");
        run_op(-64'sd5, 64'd0, 1'b1, 1'b1, 1'b0, 0, "div_by_zero");
        run_op(64'hDEAD_0000_FFFF_FFF8, 64'd3, 1'b1, 1'b1, 1'b1, 0, "divw_m8_3");
        run_op(64'h0000_1234_8000_0000, 64'd1, 1'b0, 1'b0, 1'b1, 0, "divuw_msb");
        run_op(64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 0, "divw_overflow");
        run_op(64'd12345, 64'd100, 1'b0, 1'b0, 1'b0, 5, "hold5");

        // Flush during CALC cycle 10.
        send(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", {63'b0, in_ready}, 64'd1);
        saw = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) saw = 1;
            @(negedge clk);
        end
        check("flush_no_valid", 64'(saw), 64'd0);
        run_op(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 0, "after_flush");

        // Flush while holding a result in DONE.
        send(64'd50, 64'd5, 1'b0, 1'b0, 1'b1);
        saw = 0;
        while (!out_valid && saw < 200) begin
            @(negedge clk);
            saw++;
        end
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        check("flush_done_out_valid", {63'b0, out_valid}, 64'd0);
        check("flush_done_in_ready", {63'b0, in_ready}, 64'd1);

        // Reset in the middle of an operation clears held results.
        send(64'd999, 64'd4, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_div", div_result, 64'd0);
        check("midrst_rem", rem_result, 64'd0);
        check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 5);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs1 = 1'($urandom_range(0, 1));
            rs2 = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            case (sel)
                0: rb = 64'($urandom_range(0, 15));
                1: rb = '0;
                2: begin ra = rw ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000; rb = '1; end
                3: rb = rb >> $urandom_range(1, 60);
                default: ;
            endcase
            run_op(ra, rb, rs1, rs2, rw, $urandom_range(0, 2), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
Multi-cycle radix-2 restoring divider for the EXU, replacing the single-cycle combinational divide/remainder path. It accepts one operation over a valid/ready handshake and iterates one quotient bit per cycle. It returns quotient and remainder together, with RISC-V M-extension semantics, including the divide-by-zero and overflow rules. It adds a 32-bit word mode (DIVW/DIVUW/REMW/REMUW), a flush input, and backpressure on the result.

Parameters:
XLEN, 64, operand and result width; must be even and >= 32
WORD_W, 32, operand width in word mode
CNT_W, $clog2(XLEN+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  abort the in-flight op (pipeline redirect)
in_valid  in  1  operation request
in_ready  out  1  divider can accept a request
is_sr1_signed  in  1  dividend is signed
is_sr2_signed  in  1  divisor is signed
is_word  in  1  use low WORD_W bits; sign-extend results
sr1_data  in  XLEN  dividend
sr2_data  in  XLEN  divisor
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result
div_result  out  XLEN  quotient
rem_result  out  XLEN  remainder

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset state: IDLE. in_ready=1, out_valid=0, div_result=0, rem_result=0, counter=0.
- FSM states: IDLE, CALC, FIXUP, DONE.
  - IDLE: in_ready=1. On in_valid, latch the operands and go to CALC.
    - Latching computes the sign of each operand: signed flag AND MSB of the active width.
    - It stores the magnitudes |a| and |b|, zero-extended to XLEN.
    - It loads counter = XLEN, or WORD_W when is_word=1.
  - CALC: in_ready=0. Each cycle:
    - shift {rem, quo} left by 1.
    - trial = rem - b.
    - if trial >= 0, then rem = trial and quo[0] = 1.
    - decrement the counter; on the cycle the counter reaches 1, go to FIXUP.
  - FIXUP: one cycle.
    - Negate the quotient if sign_a XOR sign_b and b != 0.
    - Negate the remainder if sign_a.
    - Apply the special cases.
    - In word mode, sign-extend bit WORD_W-1 of both results to XLEN.
    - Register the results and go to DONE.
  - DONE: out_valid=1; results are held stable. When out_ready=1, go to IDLE. A new request is not accepted in the same cycle (in_ready is low in DONE).
- Latency: accept in cycle 0 -> out_valid in cycle N+2, where N=XLEN (66 for XLEN=64) or WORD_W in word mode (34).
- Divide by zero (active-width divisor == 0): quotient = all ones in the active width; remainder = dividend in the active width. Both are then word sign-extended where applicable.
- Signed overflow (dividend = most negative value, divisor = -1): quotient = most negative value, remainder = 0. This falls out of the magnitude arithmetic with no extra logic, and must be verified.
- Unsigned operations never negate.
- flush: in any state, returns to IDLE next cycle with out_valid=0. Flush takes priority over in_valid and out_ready in the same cycle.
- rst mid-operation: identical to flush, plus results are cleared to 0.
- Operands may change after acceptance; only the latched copies are used.

Optional Feature:
ALU_DIV_EARLY_OUT_EN
- Defined: at acceptance, a divisor of zero goes straight to FIXUP with the special-case result. Latency is 2 cycles.
- Defined: if the divisor magnitude exceeds the dividend magnitude, the result is quotient=0 and remainder=dividend, also with latency 2.
- Not defined: every operation takes the fixed N+2 latency, and the comparators are absent.

Decomposition:
- Shared package/header alu_div_pkg, holding:
  - the FSM state encoding (IDLE/CALC/FIXUP/DONE, 2 bits);
  - the WORD_W constant;
  - helper functions for word sign-extension and two's-complement negation.
- XLEN comes from the existing system config.
- One sub-module, alu_div_step: a combinational single restoring iteration. Inputs are rem, quo and divisor; outputs are the next rem and next quo.

Test Plan:
- Unsigned 64-bit: sr1=100, sr2=7 -> div=14, rem=2. out_valid asserted exactly 66 cycles after acceptance (feature off).
- Signed: sr1=-7, sr2=2 -> div=-3, rem=-1.
- Signed: sr1=7, sr2=-2 -> div=-3, rem=1.
- Overflow: sr1=0x8000_0000_0000_0000, sr2=-1, signed -> div=0x8000_0000_0000_0000, rem=0.
- Divide by zero, signed: sr1=-5, sr2=0 -> div=0xFFFF_FFFF_FFFF_FFFF, rem=-5.
- Word mode DIVW: sr1=0xDEAD_0000_FFFF_FFF8 (low word -8), sr2=3, signed -> div=0xFFFF_FFFF_FFFF_FFFE, rem=0xFFFF_FFFF_FFFF_FFFE, latency 34.
- DIVUW: sr1 low word 0x8000_0000, sr2=1 -> div=0xFFFF_FFFF_8000_0000.
- Handshake and flush:
  - hold out_ready=0 for 5 cycles -> results stable, in_ready=0;
  - assert flush in CALC cycle 10 -> out_valid never rises, in_ready=1 next cycle;
  - a new request then yields the correct result.
